// File: rtl/fetch_issue_ctrl_if.sv
// ---------------------------------------------------------------------------
// fetch_issue_ctrl_if
//
// Bundles the two handshake channels that the fetch/issue sequencer sits
// between: the instruction-memory fetch port and the execution-unit
// request/response channel.
//
// Signals (master = sequencer side, slave = memory + execution unit side):
//   fch_req_vld   master->slave  fetch request valid
//   fch_req_rdy   slave->master  memory accepts fetch request
//   fch_req_addr  master->slave  fetch address (AW bits)
//   fch_rsp_vld   slave->master  fetched data valid
//   fch_rsp_rdy   master->slave  sequencer accepts fetched data
//   fch_rsp_data  slave->master  fetched instruction (DW bits)
//   ex_req_vld    master->slave  instruction valid to execution unit
//   ex_req_rdy    slave->master  execution unit accepts instruction
//   ex_req_ir     master->slave  instruction word (DW bits)
//   ex_req_pc     master->slave  PC of that instruction (AW bits)
//   ex_rsp_taken  slave->master  branch taken (valid in ex handshake cycle)
//   ex_rsp_offset slave->master  branch offset (valid in ex handshake cycle)
// ---------------------------------------------------------------------------
interface fetch_issue_ctrl_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          fch_req_vld;
    logic          fch_req_rdy;
    logic [AW-1:0] fch_req_addr;
    logic          fch_rsp_vld;
    logic          fch_rsp_rdy;
    logic [DW-1:0] fch_rsp_data;
    logic          ex_req_vld;
    logic          ex_req_rdy;
    logic [DW-1:0] ex_req_ir;
    logic [AW-1:0] ex_req_pc;
    logic          ex_rsp_taken;
    logic [AW-1:0] ex_rsp_offset;

    // Sequencer view: drives requests and the fetch-response ready.
    modport master (
        output fch_req_vld,
        input  fch_req_rdy,
        output fch_req_addr,
        input  fch_rsp_vld,
        output fch_rsp_rdy,
        input  fch_rsp_data,
        output ex_req_vld,
        input  ex_req_rdy,
        output ex_req_ir,
        output ex_req_pc,
        input  ex_rsp_taken,
        input  ex_rsp_offset
    );

    // Memory / execution-unit view: the mirror image of master.
    modport slave (
        input  fch_req_vld,
        output fch_req_rdy,
        input  fch_req_addr,
        output fch_rsp_vld,
        input  fch_rsp_rdy,
        output fch_rsp_data,
        input  ex_req_vld,
        output ex_req_rdy,
        input  ex_req_ir,
        input  ex_req_pc,
        output ex_rsp_taken,
        output ex_rsp_offset
    );
endinterface

// File: rtl/fetch_issue_ctrl.sv
// ---------------------------------------------------------------------------
// fetch_issue_ctrl
//
// Single-issue sequencer. Owns the architectural PC, fetches one instruction
// at a time from instruction memory, presents it to the execution unit and
// then picks the next PC from the branch response returned in the issue
// handshake cycle. Also provides halt control, a retired-instruction counter
// and a sticky misaligned-PC error.
//
// Ports:
//   clk      in   clock
//   rst_n    in   asynchronous active-low reset
//   bus      master modport of fetch_issue_ctrl_if (fetch + execute channels)
//   halt     in   stop fetching at the next instruction boundary
//   pc       out  current PC
//   instret  out  retired-instruction count (wraps)
//   err      out  sticky misaligned-PC error
//
// Parameters:
//   AW      address / PC width
//   DW      instruction width
//   RST_PC  PC loaded on reset (4-byte aligned)
// ---------------------------------------------------------------------------
module fetch_issue_ctrl #(
    parameter int            AW     = 32,
    parameter int            DW     = 32,
    parameter logic [AW-1:0] RST_PC = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    fetch_issue_ctrl_if.master    bus,
    input  logic                  halt,
    output logic [AW-1:0]         pc,
    output logic [31:0]           instret,
    output logic                  err
);

    localparam logic [AW-1:0] PC_STEP = AW'(4);

    typedef enum logic [2:0] {
        ST_RST,
        ST_FETCH,
        ST_WAIT,
        ST_ISSUE,
        ST_HALT,
        ST_ERR
    } state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [DW-1:0] ir_q, ir_d;
    logic [31:0]   instret_q, instret_d;
    logic          err_q, err_d;

    logic          fchReqFire;
    logic          fchRspFire;
    logic          exFire;
    logic [AW-1:0] nextPc;
    logic          nextMisaligned;

    // Handshake qualifiers. Each one is gated by the state that owns the
    // channel, so a response or ready seen in any other state is ignored.
    always_comb begin
        fchReqFire = (state_q == ST_FETCH) && bus.fch_req_rdy;
        fchRspFire = (state_q == ST_WAIT)  && bus.fch_rsp_vld;
        exFire     = (state_q == ST_ISSUE) && bus.ex_req_rdy;
    end

    // Next-PC selection from the branch response. The sum is taken at AW
    // bits so it wraps naturally; a non-word-aligned result is a fault.
    always_comb begin
        nextPc         = bus.ex_rsp_taken ? (pc_q + bus.ex_rsp_offset)
                                          : (pc_q + PC_STEP);
        nextMisaligned = (nextPc[1:0] != 2'b00);
    end

    // State register. Reset is asynchronous so every Moore output falls
    // back to its idle value the moment rst_n drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RST;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. RST and a successful ISSUE share the boundary
    // check: halt parks the sequencer, otherwise it fetches. A misaligned
    // next PC overrides the boundary check and locks the sequencer in ERR
    // until the next reset.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RST: begin
                state_d = halt ? ST_HALT : ST_FETCH;
            end
            ST_FETCH: begin
                if (fchReqFire) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (fchRspFire) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (exFire) begin
                    if (nextMisaligned) begin
                        state_d = ST_ERR;
                    end else begin
                        state_d = halt ? ST_HALT : ST_FETCH;
                    end
                end
            end
            ST_HALT: begin
                if (!halt) begin
                    state_d = ST_FETCH;
                end
            end
            ST_ERR: begin
                state_d = ST_ERR;
            end
            default: begin
                state_d = ST_RST;
            end
        endcase
    end

    // Output decode. Valids and readies come from the state register only;
    // address, instruction and PC come straight from registers, so they are
    // stable for as long as the corresponding valid is held.
    always_comb begin
        bus.fch_req_vld = (state_q == ST_FETCH);
        bus.fch_rsp_rdy = (state_q == ST_WAIT);
        bus.ex_req_vld  = (state_q == ST_ISSUE);
    end

    assign bus.fch_req_addr = pc_q;
    assign bus.ex_req_ir    = ir_q;
    assign bus.ex_req_pc    = pc_q;
    assign pc               = pc_q;
    assign instret          = instret_q;
    assign err              = err_q;

    // Datapath next values. IR is loaded when the fetch response is taken;
    // PC, instret and err only change in the issue handshake cycle, which
    // is also the only cycle in which ex_rsp_* are looked at.
    always_comb begin
        pc_d      = pc_q;
        ir_d      = ir_q;
        instret_d = instret_q;
        err_d     = err_q;
        if (fchRspFire) begin
            ir_d = bus.fch_rsp_data;
        end
        if (exFire) begin
            pc_d      = nextPc;
            instret_d = instret_q + 32'd1;
            if (nextMisaligned) begin
                err_d = 1'b1;
            end
        end
    end

    // Datapath registers, sharing the asynchronous reset with the FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q      <= RST_PC;
            ir_q      <= '0;
            instret_q <= '0;
            err_q     <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            instret_q <= instret_d;
            err_q     <= err_d;
        end
    end

endmodule

// File: tb/tb_fetch_issue_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fetch_issue_ctrl
//
// Bench for fetch_issue_ctrl. A memory stub and an execution-unit stub
// drive the slave side of the interface with percentage-controlled randomness.
// A transaction-level model of the sequencer predicts every output each
// cycle; a set of directed scenarios additionally pins hand-computed values.
// Timeline per 10ns cycle: posedge at t, compare at t+3, stimulus and model
// update at the negedge t+5, optional asynchronous reset at t+7.
// ---------------------------------------------------------------------------
module tb_fetch_issue_ctrl;

    localparam int AW = 32;
    localparam int DW = 32;

    // What the sequencer is currently waiting for.
    localparam int P_BOOT   = 0;
    localparam int P_FETCH  = 1;
    localparam int P_WAIT   = 2;
    localparam int P_ISSUE  = 3;
    localparam int P_PARKED = 4;
    localparam int P_DEAD   = 5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        halt = 1'b0;
    logic [31:0] pc;
    logic [31:0] instret;
    logic        err;

    fetch_issue_ctrl_if #(.AW(AW), .DW(DW)) bus ();

    fetch_issue_ctrl #(.AW(AW), .DW(DW), .RST_PC(32'h0)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .halt    (halt),
        .pc      (pc),
        .instret (instret),
        .err     (err)
    );

    always #5 clk = ~clk;

    int nCompared = 0;
    int nFail     = 0;

    // Reference model state
    int          mPhase;
    logic [31:0] mPc;
    logic [31:0] mIr;
    logic [31:0] mInstret;
    logic        mErr;

    // Memory stub state
    bit          stubPending = 0;
    int          stubLat     = 0;
    logic [31:0] stubAddr    = '0;

    // Stimulus controls
    int          fchRdyPct, exRdyPct, memMaxLat, haltPct, takenPct, misalignPct, noisePct;
    bit          memFixedEn;
    logic [31:0] memWord;
    bit          brEn;
    logic [31:0] brPc, brOff;

    // Single comparison point: every check, per-cycle or literal, ends here.
    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nFail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit pct(input int p);
        return int'($urandom_range(0, 99)) < p;
    endfunction

    function automatic logic [31:0] memRead(input logic [31:0] a);
        return memFixedEn ? memWord : ((a * 32'h9E37_79B1) ^ 32'h0000_0013);
    endfunction

    task automatic modelReset();
        mPhase   = P_BOOT;
        mPc      = 32'h0;
        mIr      = 32'h0;
        mInstret = 32'h0;
        mErr     = 1'b0;
    endtask

    // Advance the model by one clock using the inputs just applied.
    task automatic modelStep();
        longint unsigned step, target;
        if (!rst_n) begin
            modelReset();
        end else begin
            case (mPhase)
                P_BOOT:   mPhase = halt ? P_PARKED : P_FETCH;
                P_FETCH:  if (bus.fch_req_rdy) mPhase = P_WAIT;
                P_WAIT: begin
                    if (bus.fch_rsp_vld) begin
                        mIr    = bus.fch_rsp_data;
                        mPhase = P_ISSUE;
                    end
                end
                P_ISSUE: begin
                    if (bus.ex_req_rdy) begin
                        step     = bus.ex_rsp_taken ? longint'(bus.ex_rsp_offset) : 64'd4;
                        target   = (longint'(mPc) + step) % (64'd1 << 32);
                        mPc      = target[31:0];
                        mInstret = 32'((longint'(mInstret) + 1) % (64'd1 << 32));
                        if (target % 4 != 0) begin
                            mErr   = 1'b1;
                            mPhase = P_DEAD;
                        end else begin
                            mPhase = halt ? P_PARKED : P_FETCH;
                        end
                    end
                end
                P_PARKED: if (!halt) mPhase = P_FETCH;
                default:  mPhase = P_DEAD;
            endcase
        end
    endtask

    task automatic checkOutput();
        cmp("fch_req_vld",  bus.fch_req_vld,  (mPhase == P_FETCH));
        cmp("fch_req_addr", bus.fch_req_addr, mPc);
        cmp("fch_rsp_rdy",  bus.fch_rsp_rdy,  (mPhase == P_WAIT));
        cmp("ex_req_vld",   bus.ex_req_vld,   (mPhase == P_ISSUE));
        cmp("ex_req_ir",    bus.ex_req_ir,    mIr);
        cmp("ex_req_pc",    bus.ex_req_pc,    mPc);
        cmp("pc",           pc,               mPc);
        cmp("instret",      instret,          mInstret);
        cmp("err",          err,              mErr);
    endtask

    // Drive the slave side for the coming clock edge, track the memory
    // stub's outstanding fetch, then step the model.
    task automatic applyStimulus();
        logic [31:0] off;
        bus.fch_req_rdy = pct(fchRdyPct);
        if (stubPending && stubLat == 0) begin
            bus.fch_rsp_vld  = 1'b1;
            bus.fch_rsp_data = memRead(stubAddr);
        end else begin
            bus.fch_rsp_vld  = !stubPending && pct(noisePct);
            bus.fch_rsp_data = $urandom;
        end
        off = 32'($urandom_range(0, 63)) * 32'd4 - 32'd128;
        if (pct(misalignPct)) off = off + 32'($urandom_range(1, 3));
        bus.ex_req_rdy    = pct(exRdyPct);
        bus.ex_rsp_taken  = pct(takenPct);
        bus.ex_rsp_offset = off;
        if (brEn && mPhase == P_ISSUE && mPc == brPc) begin
            bus.ex_rsp_taken  = 1'b1;
            bus.ex_rsp_offset = brOff;
        end
        halt = pct(haltPct);
        if (rst_n) begin
            if (bus.fch_rsp_vld && bus.fch_rsp_rdy) stubPending = 0;
            else if (stubPending && stubLat > 0) stubLat--;
            if (bus.fch_req_vld && bus.fch_req_rdy) begin
                stubPending = 1;
                stubAddr    = bus.fch_req_addr;
                stubLat     = int'($urandom_range(0, memMaxLat));
            end
        end
        modelStep();
    endtask

    task automatic advance(input int n);
        repeat (n) begin
            @(negedge clk);
            applyStimulus();
        end
    endtask

    // Hold reset for a few edges, then release on a negedge (cycle k=0).
    task automatic releaseReset(input int hold);
        advance(hold);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus();
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must drop at once.
    task automatic pulseReset(input int hold);
        #2;
        rst_n = 1'b0;
        modelReset();
        stubPending = 0;
        #1;
        cmp("rst fch_req_vld",  bus.fch_req_vld,  1'b0);
        cmp("rst fch_rsp_rdy",  bus.fch_rsp_rdy,  1'b0);
        cmp("rst ex_req_vld",   bus.ex_req_vld,   1'b0);
        cmp("rst ex_req_ir",    bus.ex_req_ir,    32'h0);
        cmp("rst fch_req_addr", bus.fch_req_addr, 32'h0);
        cmp("rst instret",      instret,          32'h0);
        cmp("rst err",          err,              1'b0);
        releaseReset(hold);
    endtask

    task automatic setDirected();
        fchRdyPct = 100; exRdyPct = 100; memMaxLat = 0; haltPct = 0;
        takenPct = 0; misalignPct = 0; noisePct = 0;
        memFixedEn = 1; memWord = 32'h0000_0013; brEn = 0;
        brPc = '0; brOff = '0;
    endtask

    // Per-cycle comparison against the model, away from the clock edge.
    initial begin
        forever begin
            @(posedge clk);
            #3;
            checkOutput();
        end
    end

    initial begin
        int deadCycles;
        bus.fch_req_rdy = 0; bus.fch_rsp_vld = 0; bus.fch_rsp_data = '0;
        bus.ex_req_rdy = 0; bus.ex_rsp_taken = 0; bus.ex_rsp_offset = '0;
        modelReset();
        setDirected();
        releaseReset(2);

        // Straight-line code, zero-wait memory, always-ready execution.
        advance(1);  cmp("t1 addr k1", bus.fch_req_addr, 32'h0);
                     cmp("t1 vld k1",  bus.fch_req_vld,  1'b1);
        advance(3);  cmp("t1 addr k4", bus.fch_req_addr, 32'h4);
        advance(2);  cmp("t1 expc k6", bus.ex_req_pc,    32'h4);
                     cmp("t1 ir k6",   bus.ex_req_ir,    32'h13);
        advance(4);  cmp("t1 instret k10", instret,      32'd3);
                     cmp("t1 addr k10",    bus.fch_req_addr, 32'hC);

        // Taken branch at PC 0x8 with offset 0x10.
        memWord = 32'h4F; brEn = 1; brPc = 32'h8; brOff = 32'h10;
        pulseReset(2);
        advance(9);  cmp("t2 ir k9",   bus.ex_req_ir, 32'h4F);
                     cmp("t2 expc k9", bus.ex_req_pc, 32'h8);
        advance(1);  cmp("t2 addr k10",    bus.fch_req_addr, 32'h18);
                     cmp("t2 instret k10", instret,          32'd3);
        advance(2);  cmp("t2 expc k12",    bus.ex_req_pc,    32'h18);
        advance(1);  cmp("t2 instret k13", instret,          32'd4);
                     cmp("t2 addr k13",    bus.fch_req_addr, 32'h1C);

        // Backpressure on both channels.
        setDirected();
        fchRdyPct = 0;
        pulseReset(2);
        advance(5);  cmp("t3 vld k5",  bus.fch_req_vld,  1'b1);
                     cmp("t3 addr k5", bus.fch_req_addr, 32'h0);
        fchRdyPct = 100; exRdyPct = 0;
        advance(6);  cmp("t3 exvld k12",   bus.ex_req_vld, 1'b1);
                     cmp("t3 expc k12",    bus.ex_req_pc,  32'h0);
                     cmp("t3 instret k12", instret,        32'd0);
        exRdyPct = 100;
        advance(2);  cmp("t3 instret k14", instret,          32'd1);
                     cmp("t3 addr k14",    bus.fch_req_addr, 32'h4);

        // Halt raised while waiting on the fetch at 0x4.
        setDirected();
        pulseReset(2);
        advance(4);
        haltPct = 100;
        advance(3);  cmp("t4 vld k7",     bus.fch_req_vld, 1'b0);
                     cmp("t4 pc k7",      pc,              32'h8);
                     cmp("t4 instret k7", instret,         32'd2);
        advance(2);  cmp("t4 vld k9",     bus.fch_req_vld, 1'b0);
        haltPct = 0;
        advance(1);  cmp("t4 vld k10",    bus.fch_req_vld, 1'b0);
        advance(1);  cmp("t4 vld k11",    bus.fch_req_vld, 1'b1);
                     cmp("t4 addr k11",   bus.fch_req_addr, 32'h8);

        // Misaligned branch target locks up until reset.
        brEn = 1; brPc = 32'h10; brOff = 32'h2;
        pulseReset(2);
        advance(16); cmp("t5 err k16",     err,            1'b1);
                     cmp("t5 pc k16",      pc,             32'h12);
                     cmp("t5 instret k16", instret,        32'd5);
                     cmp("t5 exvld k16",   bus.ex_req_vld, 1'b0);
        advance(20); cmp("t5 err k36",     err,            1'b1);
                     cmp("t5 vld k36",     bus.fch_req_vld, 1'b0);
        brEn = 0;
        pulseReset(2);
        advance(1);  cmp("t5 err after rst", err,              1'b0);
                     cmp("t5 addr after rst", bus.fch_req_addr, 32'h0);

        // Reset lands in WAIT while the fetch response is on the bus.
        setDirected();
        pulseReset(2);
        advance(2);  cmp("t6 rdy k2", bus.fch_rsp_rdy, 1'b1);
        noisePct = 100;
        pulseReset(2);
        advance(1);  cmp("t6 addr k1",    bus.fch_req_addr, 32'h0);
                     cmp("t6 rdy k1",     bus.fch_rsp_rdy,  1'b0);
                     cmp("t6 instret k1", instret,          32'd0);
        advance(3);  cmp("t6 addr k4",    bus.fch_req_addr, 32'h4);

        // Randomised segments with occasional resets.
        deadCycles = 0;
        for (int seg = 0; seg < 30; seg++) begin
            fchRdyPct   = int'($urandom_range(30, 100));
            exRdyPct    = int'($urandom_range(30, 100));
            memMaxLat   = int'($urandom_range(0, 4));
            haltPct     = int'($urandom_range(0, 20));
            takenPct    = int'($urandom_range(0, 60));
            misalignPct = int'($urandom_range(0, 5));
            noisePct    = int'($urandom_range(0, 50));
            memFixedEn  = 0;
            for (int c = 0; c < 100; c++) begin
                advance(1);
                deadCycles = (mPhase == P_DEAD) ? deadCycles + 1 : 0;
                if (deadCycles > 3 || pct(1)) begin
                    pulseReset(int'($urandom_range(1, 3)));
                    deadCycles = 0;
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFail);
        $finish;
    end

endmodule

// File: doc/fetch_issue_ctrl.md
Name: fetch_issue_ctrl

Overview:
- Single-issue sequencer between the instruction memory port and the execution unit's iexec request/response channel.
- Owns the architectural PC and fetches one instruction at a time.
- Presents each fetched instruction to the execution unit, then selects the next PC from the branch response (taken/offset) returned in the handshake cycle.
- Provides halt control, a retired-instruction counter and a sticky misalignment error.

Parameters:
- AW, 32, address/PC width
- DW, 32, instruction width
- RST_PC, 0, PC loaded on reset (must be 4-byte aligned)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- fch_req_vld  out  1  fetch request valid
- fch_req_rdy  in  1  memory accepts fetch request
- fch_req_addr  out  AW  fetch address (= current PC)
- fch_rsp_vld  in  1  fetch data valid
- fch_rsp_rdy  out  1  controller accepts fetch data
- fch_rsp_data  in  DW  fetched instruction
- ex_req_vld  out  1  instruction valid to execution unit
- ex_req_rdy  in  1  execution unit accepts instruction
- ex_req_ir  out  DW  instruction word
- ex_req_pc  out  AW  PC of that instruction
- ex_rsp_taken  in  1  branch taken, valid only in the ex handshake cycle
- ex_rsp_offset  in  AW  branch offset, valid only in the ex handshake cycle
- halt  in  1  stop fetching at the next instruction boundary
- pc  out  AW  current PC
- instret  out  32  retired-instruction count
- err  out  1  sticky misaligned-PC error

Behaviour:
- Interface: one clock `clk`; reset `rst_n` is asynchronous and active-low.
- States: RST, FETCH, WAIT, ISSUE, HALT, ERR. State, PC, IR, instret and err are registers.
- All handshake outputs are decoded from the state register only (Moore).
- Reset values:
  - state = RST, pc = RST_PC, IR = 0, instret = 0, err = 0.
  - Hence fch_req_vld = 0, fch_rsp_rdy = 0, ex_req_vld = 0.
  - ex_req_ir = 0, ex_req_pc = RST_PC, fch_req_addr = RST_PC.
- Boundary check (applied when leaving RST or ISSUE):
  - halt = 1 -> HALT.
  - halt = 0 -> FETCH.
- RST: leaves on the first clock edge after reset deassertion, via the boundary check.
- FETCH:
  - fch_req_vld = 1, fch_req_addr = pc.
  - Goes to WAIT on fch_req_vld & fch_req_rdy.
  - vld and addr are held stable until accepted; halt is ignored here.
- WAIT:
  - fch_rsp_rdy = 1.
  - On fch_rsp_vld: IR <= fch_rsp_data, go to ISSUE.
  - fch_rsp_vld is never accepted in any other state.
- ISSUE:
  - ex_req_vld = 1, ex_req_ir = IR, ex_req_pc = pc, all held stable until accepted.
  - On ex_req_vld & ex_req_rdy:
    - next_pc = ex_rsp_taken ? pc + ex_rsp_offset : pc + 4, modulo 2^AW (wrap, no carry out).
    - pc <= next_pc; instret <= instret + 1, wrapping 0xFFFFFFFF -> 0.
    - If next_pc[1:0] != 0: err <= 1, go to ERR.
    - Otherwise apply the boundary check.
- HALT: all valids 0; go to FETCH the first cycle halt = 0.
- ERR:
  - Terminal until reset; all valids 0.
  - pc holds the faulting next_pc; err = 1.
- Latency and throughput:
  - First fch_req_vld is seen 1 cycle after reset release.
  - With zero-wait memory (rsp one cycle after req) and an always-ready execution unit, one instruction retires every 3 cycles (FETCH, WAIT, ISSUE).
  - Exactly one fetch is outstanding, so no flush is needed on taken branches.
- Reset mid-operation: all outputs return to reset values immediately (asynchronous). A fetch response arriving after reset is not accepted (rdy = 0 in RST/FETCH).
- ex_rsp_* are sampled only in the ISSUE handshake cycle and ignored otherwise.

Test Plan:
1. Zero-wait memory returning 0x00000013 for every fetch, ex_req_rdy held 1 after reset, RST_PC = 0 -> fch_req_addr sequence 0x0, 0x4, 0x8, ..., each ex_req_pc matching; instret = 3 after 9 cycles.
2. Instruction 0x4F at PC 0x8, ex_rsp_taken = 1, offset = 0x10 in its handshake -> next fch_req_addr = 0x18, instret increments by 1, no fetch at 0xC.
3. fch_req_rdy low 5 cycles, then ex_req_rdy low 4 cycles -> fch_req_vld/addr, then ex_req_vld/ir/pc, held constant throughout; no instret change until accept.
4. halt raised while in WAIT at PC 0x4 -> instruction at 0x4 issues and retires, then HALT with no fch_req_vld; halt dropped -> next fetch at 0x8 one cycle later.
5. Taken branch with offset 0x2 at PC 0x10 -> err = 1, pc = 0x12, state ERR, no valids for 20 cycles; rst_n pulse clears err and restarts at RST_PC.
6. rst_n asserted during WAIT with fch_rsp_vld arriving that cycle -> outputs reset asynchronously, response ignored, first fetch after release at RST_PC, instret = 0.
